// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver core and its controller.
// Handshake: rx_dv_o is a one-cycle strobe with no ready; data_o and the
// flags are valid in that cycle and hold until the next strobe.
interface uart_rx_if #(
  parameter int DataWidth = 8
);
  logic                 tick_i;
  logic                 rx_en_i;
  logic                 rx_data_i;
  logic                 rx_dv_o;
  logic [DataWidth-1:0] data_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 break_o;
  logic                 busy_o;
  logic [2:0]           state_o;

  modport slave (
    input  tick_i, rx_en_i, rx_data_i,
    output rx_dv_o, data_o, parity_err_o, frame_err_o, break_o, busy_o, state_o
  );

  modport master (
    output tick_i, rx_en_i, rx_data_i,
    input  rx_dv_o, data_o, parity_err_o, frame_err_o, break_o, busy_o, state_o
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input synchroniser, oversampled bit timing with a
// 3-sample majority vote, optional parity, 1 or 2 stop bits, false-start
// rejection and line-break detection. state_o exposes the FSM for debug.
module uart_rx_core #(
  parameter int DataWidth      = 8,
  parameter int OverSampleRate = 16,
  parameter int ParityMode     = 0,
  parameter int StopBits       = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  uart_rx_if.slave  bus
);
  localparam int CW = $clog2(OverSampleRate);
  localparam int IW = $clog2(DataWidth);
  localparam logic [CW-1:0] C_LO  = CW'(OverSampleRate / 2 - 1);
  localparam logic [CW-1:0] C_MID = CW'(OverSampleRate / 2);
  localparam logic [CW-1:0] C_HI  = CW'(OverSampleRate / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(OverSampleRate - 1);
  localparam logic [IW-1:0] LAST  = IW'(DataWidth - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 s0, s1;
  logic                 maj;
  logic [DataWidth-1:0] shift_q;
  logic                 par_bit, par_err_p;
  logic                 stop_idx, stop_low;
  logic                 is_brk;
  logic                 rx_dv, pe, fe, brk, busy;
  logic [DataWidth-1:0] data_q;

  assign maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign is_brk = (shift_q == '0) & ~par_bit & ~maj & ((StopBits == 1) | stop_low);

  assign bus.rx_dv_o      = rx_dv;
  assign bus.data_o       = data_q;
  assign bus.parity_err_o = pe;
  assign bus.frame_err_o  = fe;
  assign bus.break_o      = brk;
  assign bus.busy_o       = busy;
  assign bus.state_o      = state;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx_data_i;
      rx_s <= rx_m;
    end
  end

  // Receiver FSM: tick counter, sample capture, deserialiser and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      s0        <= 1'b0;
      s1        <= 1'b0;
      shift_q   <= '0;
      par_bit   <= 1'b0;
      par_err_p <= 1'b0;
      stop_idx  <= 1'b0;
      stop_low  <= 1'b0;
      rx_dv     <= 1'b0;
      data_q    <= '0;
      pe        <= 1'b0;
      fe        <= 1'b0;
      brk       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_dv <= 1'b0;
      if (!bus.rx_en_i) begin
        // Disabling drops any partial frame; results hold.
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        if (state != IDLE && state != BRK_WAIT && bus.tick_i) begin
          cnt <= cnt + 1'b1;
          if (cnt == C_LO)  s0 <= rx_s;
          if (cnt == C_MID) s1 <= rx_s;
        end
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state     <= START;
              cnt       <= '0;
              idx       <= '0;
              stop_idx  <= 1'b0;
              stop_low  <= 1'b0;
              par_bit   <= 1'b0;
              par_err_p <= 1'b0;
              busy      <= 1'b1;
            end
          end
          START: begin
            if (bus.tick_i) begin
              if (cnt == C_HI && maj) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
              end else if (cnt == C_END) begin
                state <= DATA;
                cnt   <= '0;
              end
            end
          end
          DATA: begin
            if (bus.tick_i) begin
              if (cnt == C_HI) shift_q[idx] <= maj;
              if (cnt == C_END) begin
                cnt <= '0;
                if (idx == LAST) begin
                  idx   <= '0;
                  state <= (ParityMode != 0) ? PARITY : STOP;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end
          end
          PARITY: begin
            if (bus.tick_i) begin
              if (cnt == C_HI) begin
                par_bit   <= maj;
                par_err_p <= ((^shift_q) ^ maj) != (ParityMode == 2);
              end
              if (cnt == C_END) begin
                state <= STOP;
                cnt   <= '0;
              end
            end
          end
          STOP: begin
            if (bus.tick_i) begin
              if (cnt == C_HI) begin
                if (stop_idx == 1'(StopBits - 1)) begin
                  // Final stop bit: complete at mid-bit to absorb baud skew.
                  rx_dv  <= 1'b1;
                  data_q <= shift_q;
                  pe     <= par_err_p;
                  fe     <= stop_low | ~maj;
                  brk    <= is_brk;
                  busy   <= is_brk;
                  state  <= is_brk ? BRK_WAIT : IDLE;
                  cnt    <= '0;
                end else begin
                  stop_low <= ~maj;
                end
              end else if (cnt == C_END) begin
                stop_idx <= 1'b1;
                cnt      <= '0;
              end
            end
          end
          BRK_WAIT: begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: three instances (even parity / odd parity /
// no parity with two stop bits) share one tick; a scoreboard per instance
// holds expected {busy, break, frame_err, parity_err, data} per frame.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int CPB = 64;  // clocks per bit: tick every 4 clocks, 16 ticks per bit

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] line = 3'b111;
  logic [2:0] en   = 3'b000;
  int         n_vec = 0;
  int         n_err = 0;
  logic [11:0] exp_q[3][$];

  // Clock and reset
  always #5 clk = ~clk;

  uart_rx_if #(.DataWidth(8)) if_a ();
  uart_rx_if #(.DataWidth(8)) if_b ();
  uart_rx_if #(.DataWidth(8)) if_c ();

  assign if_a.tick_i = tick;  assign if_a.rx_en_i = en[0];  assign if_a.rx_data_i = line[0];
  assign if_b.tick_i = tick;  assign if_b.rx_en_i = en[1];  assign if_b.rx_data_i = line[1];
  assign if_c.tick_i = tick;  assign if_c.rx_en_i = en[2];  assign if_c.rx_data_i = line[2];

  uart_rx_core #(.DataWidth(8), .OverSampleRate(16), .ParityMode(1), .StopBits(1)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(if_a.slave));
  uart_rx_core #(.DataWidth(8), .OverSampleRate(16), .ParityMode(2), .StopBits(1)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(if_b.slave));
  uart_rx_core #(.DataWidth(8), .OverSampleRate(16), .ParityMode(0), .StopBits(2)) u_c (
    .clk_i(clk), .rst_i(rst), .bus(if_c.slave));

  // Oversample tick: one-cycle pulse every 4 clocks, driven on the falling edge.
  initial begin : tick_gen
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tick = (tc == 0);
      tc = (tc + 1) % 4;
    end
  end

  function automatic logic [11:0] mk(input logic busy, input logic brk, input logic fe,
                                     input logic pe, input logic [7:0] d);
    return {busy, brk, fe, pe, d};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  // Driver tasks: the line changes on the falling edge.
  task automatic drive(input int inst, input logic v, input int cycles);
    line[inst] = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input int pmode,
                            input logic force_par, input logic par_val,
                            input int nstop, input int cpb);
    logic p;
    drive(inst, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(inst, d[i], cpb);
    if (pmode != 0) begin
      p = ^d;
      if (pmode == 2) p = ~p;
      if (force_par) p = par_val;
      drive(inst, p, cpb);
    end
    for (int i = 0; i < nstop; i++) drive(inst, 1'b1, cpb);
  endtask

  // Scoreboard monitor: pop and compare on every rx_dv_o strobe.
  task automatic check_dv(input int inst, input logic [11:0] got);
    logic [11:0] e;
    if (exp_q[inst].size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL dv_unexpected inst=%0d got=%h required=none", inst, got);
    end else begin
      e = exp_q[inst].pop_front();
      check($sformatf("frame_inst%0d", inst), 32'(got), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (if_a.rx_dv_o)
      check_dv(0, {if_a.busy_o, if_a.break_o, if_a.frame_err_o, if_a.parity_err_o, if_a.data_o});
    if (if_b.rx_dv_o)
      check_dv(1, {if_b.busy_o, if_b.break_o, if_b.frame_err_o, if_b.parity_err_o, if_b.data_o});
    if (if_c.rx_dv_o)
      check_dv(2, {if_c.busy_o, if_c.break_o, if_c.frame_err_o, if_c.parity_err_o, if_c.data_o});
  end

  // Directed stimulus
  initial begin
    repeat (3) @(negedge clk);
    check("rst_dv",    32'(if_a.rx_dv_o), 0);
    check("rst_data",  32'(if_a.data_o), 0);
    check("rst_flags", 32'({if_a.parity_err_o, if_a.frame_err_o, if_a.break_o}), 0);
    check("rst_busy",  32'(if_a.busy_o), 0);
    check("rst_state", 32'(if_a.state_o), 0);
    rst = 1'b0;
    en  = 3'b111;
    repeat (CPB) @(negedge clk);

    // Even parity, 0xA5 (four ones -> parity 0)
    exp_q[0].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5));
    send_frame(0, 8'hA5, 1, 1'b0, 1'b0, 1, CPB);
    drive(0, 1'b1, 2 * CPB);

    // Glitch: low for 5 ticks
    drive(0, 1'b0, 20);
    check("glitch_busy_set", 32'(if_a.busy_o), 1);
    drive(0, 1'b1, 2 * CPB);
    check("glitch_busy_clr", 32'(if_a.busy_o), 0);
    check("glitch_state",    32'(if_a.state_o), 0);
    check("glitch_data",     32'(if_a.data_o), 32'h A5);

    // Line break: 12 bit times low, then 0x55
    exp_q[0].push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00));
    drive(0, 1'b0, 12 * CPB);
    check("brk_wait_state", 32'(if_a.state_o), 5);
    check("brk_wait_busy",  32'(if_a.busy_o), 1);
    drive(0, 1'b1, 2 * CPB);
    check("brk_idle_state", 32'(if_a.state_o), 0);
    exp_q[0].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h55));
    send_frame(0, 8'h55, 1, 1'b0, 1'b0, 1, CPB);
    drive(0, 1'b1, 2 * CPB);

    // Reset mid-DATA
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, CPB);
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, CPB / 2);
    check("mid_data_state", 32'(if_a.state_o), 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_data",  32'(if_a.data_o), 0);
    check("rst_mid_busy",  32'(if_a.busy_o), 0);
    check("rst_mid_state", 32'(if_a.state_o), 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, CPB);
    exp_q[0].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A));
    send_frame(0, 8'h5A, 1, 1'b0, 1'b0, 1, CPB);
    drive(0, 1'b1, 2 * CPB);

    // Enable drop mid-DATA
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, CPB);
    drive(0, 1'b1, CPB / 2);
    check("en_mid_data_state", 32'(if_a.state_o), 2);
    en[0] = 1'b0;
    @(negedge clk);
    check("en_drop_state", 32'(if_a.state_o), 0);
    check("en_drop_busy",  32'(if_a.busy_o), 0);
    check("en_drop_data",  32'(if_a.data_o), 32'h5A);
    drive(0, 1'b1, CPB);
    en[0] = 1'b1;
    drive(0, 1'b1, CPB);
    exp_q[0].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'hC3));
    send_frame(0, 8'hC3, 1, 1'b0, 1'b0, 1, CPB);
    drive(0, 1'b1, 2 * CPB);

    // Odd parity: 0x3C with wrong parity 0, then a good frame
    exp_q[1].push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C));
    send_frame(1, 8'h3C, 2, 1'b1, 1'b0, 1, CPB);
    drive(1, 1'b1, 2 * CPB);
    exp_q[1].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C));
    send_frame(1, 8'h3C, 2, 1'b0, 1'b0, 1, CPB);
    drive(1, 1'b1, 2 * CPB);

    // Two stop bits, back-to-back, transmitter ~3% fast
    exp_q[2].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h81));
    exp_q[2].push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h7E));
    send_frame(2, 8'h81, 0, 1'b0, 1'b0, 2, 62);
    send_frame(2, 8'h7E, 0, 1'b0, 1'b0, 2, 62);
    drive(2, 1'b1, 2 * CPB);

    for (int i = 0; i < 3; i++)
      check($sformatf("drain_inst%0d", i), 32'(exp_q[i].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
